// File: rtl/axi4_master_burst_engine_if.sv
// Bundle of client-side command/data streams and the five AXI4 channels seen by the burst engine.
// The master modport is the engine's view; the slave modport is the environment (client + AXI slave).
interface axi4_master_burst_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
);
    // client command
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [ID_WIDTH-1:0]     cmd_id;
    logic [LEN_WIDTH-1:0]    cmd_len;
    // client write source / read sink / completion
    logic                    wr_valid;
    logic                    wr_ready;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_last;
    logic                    done;
    logic [1:0]              done_resp;
    logic                    done_err;
    // AXI4 write address / data / response
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [ID_WIDTH-1:0]     AWID;
    logic [LEN_WIDTH-1:0]    AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    BVALID;
    logic                    BREADY;
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    // AXI4 read address / data
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [ID_WIDTH-1:0]     ARID;
    logic [LEN_WIDTH-1:0]    ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    RVALID;
    logic                    RREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [ID_WIDTH-1:0]     RID;
    logic [1:0]              RRESP;
    logic                    RLAST;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_id, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data, wr_strb,
        output wr_ready,
        output rd_valid, rd_data, rd_last,
        input  rd_ready,
        output done, done_resp, done_err,
        output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        input  AWREADY,
        output WVALID, WDATA, WSTRB, WLAST,
        input  WREADY,
        input  BVALID, BID, BRESP,
        output BREADY,
        output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST,
        input  ARREADY,
        input  RVALID, RDATA, RID, RRESP, RLAST,
        output RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_id, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data, wr_strb,
        input  wr_ready,
        input  rd_valid, rd_data, rd_last,
        output rd_ready,
        input  done, done_resp, done_err,
        input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        output AWREADY,
        input  WVALID, WDATA, WSTRB, WLAST,
        output WREADY,
        output BVALID, BID, BRESP,
        input  BREADY,
        input  ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST,
        output ARREADY,
        output RVALID, RDATA, RID, RRESP, RLAST,
        input  RREADY
    );
endinterface

// File: rtl/axi4_master_burst_engine.sv
// AXI4 master burst engine: one command at a time becomes a single INCR burst (AW->W->B or AR->R),
// with write data from a valid/ready source, read data to a valid/ready sink, and a done pulse.
module axi4_master_burst_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
) (
    input logic CLK,
    input logic RST,
    axi4_master_burst_engine_if.master bus
);
    localparam int SIZE = $clog2(DATA_WIDTH / 8);
    localparam int BW   = LEN_WIDTH + SIZE + 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R
    } state_t;

    state_t                state_q;
    logic                  cmd_ready_q;
    logic                  awvalid_q;
    logic                  arvalid_q;
    logic                  bready_q;
    logic                  done_q;
    logic [1:0]            done_resp_q;
    logic                  done_err_q;
    logic                  rresp_hit_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_cnt_q;

    logic                  cmd_fire_d;
    logic                  w_fire_d;
    logic                  r_fire_d;
    logic                  last_cnt_d;
    logic                  r_end_d;
    logic                  r_err_d;
    logic                  crosses_4k_d;
    logic [BW-1:0]         span_d;

    // End offset of the burst within its 4 KB page; anything past 4096 would cross the page.
    assign span_d       = BW'(bus.cmd_addr[11:0]) + ((BW'(bus.cmd_len) + BW'(1)) << SIZE);
    assign crosses_4k_d = span_d > BW'(4096);

    assign cmd_fire_d = bus.cmd_valid && cmd_ready_q;
    assign w_fire_d   = bus.WVALID && bus.WREADY;
    assign r_fire_d   = bus.RVALID && bus.RREADY;
    assign last_cnt_d = (beat_cnt_q == len_q);
    assign r_end_d    = bus.RLAST || last_cnt_d;
    assign r_err_d    = (bus.RID != id_q) || (bus.RLAST && !last_cnt_d) || (!bus.RLAST && last_cnt_d);

    // Address channels
    assign bus.AWVALID = awvalid_q;
    assign bus.AWADDR  = addr_q;
    assign bus.AWID    = id_q;
    assign bus.AWLEN   = len_q;
    assign bus.AWSIZE  = 3'(SIZE);
    assign bus.AWBURST = 2'b01;
    assign bus.ARVALID = arvalid_q;
    assign bus.ARADDR  = addr_q;
    assign bus.ARID    = id_q;
    assign bus.ARLEN   = len_q;
    assign bus.ARSIZE  = 3'(SIZE);
    assign bus.ARBURST = 2'b01;

    // Data streams pass straight through, gated so nothing moves outside the data phase.
    assign bus.WVALID   = (state_q == S_W) && bus.wr_valid;
    assign bus.wr_ready = (state_q == S_W) && bus.WREADY;
    assign bus.WDATA    = bus.wr_data;
    assign bus.WSTRB    = bus.wr_strb;
    assign bus.WLAST    = (state_q == S_W) && last_cnt_d;
    assign bus.BREADY   = bready_q;

    assign bus.RREADY   = (state_q == S_R) && bus.rd_ready;
    assign bus.rd_valid = (state_q == S_R) && bus.RVALID;
    assign bus.rd_data  = bus.RDATA;
    assign bus.rd_last  = bus.RLAST;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.done      = done_q;
    assign bus.done_resp = done_resp_q;
    assign bus.done_err  = done_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= 2'b00;
            done_err_q  <= 1'b0;
            rresp_hit_q <= 1'b0;
            addr_q      <= '0;
            id_q        <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire_d) begin
                        addr_q      <= bus.cmd_addr;
                        id_q        <= bus.cmd_id;
                        len_q       <= bus.cmd_len;
                        beat_cnt_q  <= '0;
                        rresp_hit_q <= 1'b0;
                        if (crosses_4k_d) begin
                            // Rejected commands complete immediately with SLVERR and no bus traffic.
                            done_q      <= 1'b1;
                            done_resp_q <= 2'b10;
                            done_err_q  <= 1'b1;
                        end else begin
                            done_resp_q <= 2'b00;
                            done_err_q  <= 1'b0;
                            cmd_ready_q <= 1'b0;
                            if (bus.cmd_write) begin
                                awvalid_q <= 1'b1;
                                state_q   <= S_AW;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= S_AR;
                            end
                        end
                    end
                end
                S_AW: begin
                    if (bus.AWREADY) begin
                        awvalid_q <= 1'b0;
                        state_q   <= S_W;
                    end
                end
                S_W: begin
                    if (w_fire_d) begin
                        if (last_cnt_d) begin
                            beat_cnt_q <= '0;
                            bready_q   <= 1'b1;
                            state_q    <= S_B;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
                        end
                    end
                end
                S_B: begin
                    if (bus.BVALID) begin
                        bready_q    <= 1'b0;
                        done_q      <= 1'b1;
                        done_resp_q <= bus.BRESP;
                        done_err_q  <= (bus.BID != id_q);
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_AR: begin
                    if (bus.ARREADY) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (r_fire_d) begin
                        // First error response wins; otherwise the final beat's response is reported.
                        if (!rresp_hit_q && (bus.RRESP[1] || r_end_d)) begin
                            done_resp_q <= bus.RRESP;
                        end
                        if (bus.RRESP[1]) begin
                            rresp_hit_q <= 1'b1;
                        end
                        if (r_err_d) begin
                            done_err_q <= 1'b1;
                        end
                        if (r_end_d) begin
                            beat_cnt_q  <= '0;
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    awvalid_q   <= 1'b0;
                    arvalid_q   <= 1'b0;
                    bready_q    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_master_burst_engine.sv
// Directed + randomized bench for the AXI4 master burst engine with a word-addressed slave memory
// and a command-level reference model (expected beats, folded response and error flag per command).
module tb_axi4_master_burst_engine;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int LW = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    axi4_master_burst_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

    axi4_master_burst_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] wdata [257];
    logic [1:0]  rresp_arr [257];
    logic [31:0] got_q [$];

    // per-command slave/source behaviour knobs
    int          pct;
    int          aw_stall;
    int          ar_stall;
    logic [3:0]  bid_val;
    logic [1:0]  bresp_val;
    int          rlast_at;
    int          rid_bad_at;
    int          abort_beat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit crosses(input logic [31:0] a, input int len);
        return (int'(a[11:0]) + (len + 1) * (DW / 8)) > 4096;
    endfunction

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {16'hD00D, a[15:0]};
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_id = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_strb = '0; bus.rd_ready = 1'b0;
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BID = '0; bus.BRESP = '0;
        bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0; bus.RID = '0; bus.RRESP = '0; bus.RLAST = 1'b0;
    endtask

    task automatic set_defaults();
        pct = 50; aw_stall = 0; ar_stall = 0; bid_val = '0; bresp_val = 2'b00;
        rlast_at = -1; rid_bad_at = -1; abort_beat = -1;
        for (int k = 0; k < 257; k++) rresp_arr[k] = 2'b00;
    endtask

    // Present a command at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [3:0] id, input int len);
        @(negedge CLK);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_id = id; bus.cmd_len = LW'(len);
        #1 chk("cmd_ready_idle", bus.cmd_ready, 1);
        @(negedge CLK);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input bit fin, input logic [1:0] er, input bit ee);
        chk({tag, "_completed"}, fin, 1);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_resp"}, bus.done_resp, er);
        chk({tag, "_err"}, bus.done_err, ee);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        idle_inputs();
        @(negedge CLK);
        chk({tag, "_done_pulse"}, bus.done, 0);
        chk({tag, "_resp_held"}, bus.done_resp, er);
        $display("%s: done resp=%0d err=%0d", tag, bus.done_resp, bus.done_err);
    endtask

    task automatic reject_check(input string tag);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_resp"}, bus.done_resp, 2'b10);
        chk({tag, "_err"}, bus.done_err, 1);
        for (int c = 0; c < 3; c++) begin
            chk({tag, "_no_axvalid"}, {bus.AWVALID, bus.ARVALID}, 2'b00);
            @(negedge CLK);
        end
        chk({tag, "_done_pulse"}, bus.done, 0);
        $display("%s: rejected resp=%0d err=%0d", tag, bus.done_resp, bus.done_err);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [3:0] id, input int len);
        bit         aw_done = 0;
        bit         b_final = 0;
        bit         fin     = 0;
        int         beat    = 0;
        int         aw_cnt  = 0;
        int         budget  = 40 * (len + 1) + 100;
        bit         w_hs    = 0;
        logic [1:0] er      = bresp_val;
        bit         ee      = (bid_val != id);
        issue(1'b1, addr, id, len);
        if (crosses(addr, len)) begin
            reject_check(tag);
            return;
        end
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (b_final) begin fin = 1; break; end
            chk({tag, "_done_early"}, bus.done, 0);
            if (abort_beat >= 0 && beat == abort_beat) begin
                RST = 1'b1; bus.wr_valid = 1'b1; bus.WREADY = 1'b1; bus.BVALID = 1'b1;
                @(negedge CLK);
                chk({tag, "_rst_valids"}, {bus.AWVALID, bus.WVALID, bus.ARVALID}, 3'b000);
                chk({tag, "_rst_readys"}, {bus.BREADY, bus.RREADY, bus.wr_ready}, 3'b000);
                chk({tag, "_rst_cmd_ready"}, bus.cmd_ready, 1);
                chk({tag, "_rst_no_done"}, bus.done, 0);
                RST = 1'b0; abort_beat = -1; idle_inputs();
                @(negedge CLK);
                chk({tag, "_rst_no_done2"}, bus.done, 0);
                $display("%s: aborted by reset after %0d beats", tag, beat);
                return;
            end
            bus.AWREADY = bus.AWVALID && (aw_cnt >= aw_stall);
            if (bus.AWVALID) begin
                chk({tag, "_awaddr"}, bus.AWADDR, addr);
                chk({tag, "_awlen_id"}, {bus.AWLEN, bus.AWID}, {LW'(len), id});
                chk({tag, "_awsize_burst"}, {bus.AWSIZE, bus.AWBURST}, {3'd2, 2'b01});
                aw_cnt++;
            end
            if (!bus.wr_valid || w_hs) bus.wr_valid = (beat <= len) && ($urandom_range(99) < pct);
            bus.wr_data = wdata[beat]; bus.wr_strb = 4'hF;
            bus.WREADY  = ($urandom_range(99) < pct);
            if (beat > len) begin bus.BVALID = 1'b1; bus.BID = bid_val; bus.BRESP = bresp_val; end
            #1;
            chk({tag, "_wvalid"}, bus.WVALID, aw_done && beat <= len && bus.wr_valid);
            chk({tag, "_wr_ready"}, bus.wr_ready, aw_done && beat <= len && bus.WREADY);
            chk({tag, "_bready"}, bus.BREADY, beat > len);
            w_hs = bus.WVALID && bus.WREADY;
            if (w_hs) begin
                chk({tag, "_wdata"}, bus.WDATA, wdata[beat]);
                chk({tag, "_wlast"}, bus.WLAST, beat == len);
                mem[addr + 32'(4 * beat)] = wdata[beat];
                beat++;
            end
            if (bus.AWVALID && bus.AWREADY) aw_done = 1;
            if (bus.BVALID && bus.BREADY) b_final = 1;
            @(negedge CLK);
        end
        chk({tag, "_beats"}, beat, len + 1);
        finish_cmd(tag, fin, er, ee);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [3:0] id, input int len);
        int         eff_last = (rlast_at < 0) ? len : rlast_at;
        int         n        = ((eff_last < len) ? eff_last : len) + 1;
        bit         ar_done  = 0;
        bit         r_final  = 0;
        bit         fin      = 0;
        bit         r_hs     = 0;
        int         k        = 0;
        int         ar_cnt   = 0;
        int         budget   = 40 * (len + 1) + 100;
        logic [1:0] er       = 2'b00;
        bit         found    = 0;
        bit         ee       = (eff_last != len) || (rid_bad_at >= 0 && rid_bad_at < n);
        logic [31:0] exp_d;
        for (int j = 0; j < n; j++) begin
            if (!found && rresp_arr[j][1]) begin er = rresp_arr[j]; found = 1; end
        end
        if (!found) er = rresp_arr[n - 1];
        issue(1'b0, addr, id, len);
        if (crosses(addr, len)) begin
            reject_check(tag);
            return;
        end
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (r_final) begin fin = 1; break; end
            chk({tag, "_done_early"}, bus.done, 0);
            bus.ARREADY = bus.ARVALID && (ar_cnt >= ar_stall);
            if (bus.ARVALID) begin
                chk({tag, "_araddr"}, bus.ARADDR, addr);
                chk({tag, "_arlen_id"}, {bus.ARLEN, bus.ARID, bus.ARSIZE, bus.ARBURST}, {LW'(len), id, 3'd2, 2'b01});
                ar_cnt++;
            end
            if (ar_done && (!bus.RVALID || r_hs)) bus.RVALID = (k < n) && ($urandom_range(99) < pct);
            exp_d = slave_word(addr + 32'(4 * k));
            bus.RDATA = exp_d; bus.RRESP = rresp_arr[k]; bus.RLAST = (k == eff_last);
            bus.RID   = (k == rid_bad_at) ? id ^ 4'h1 : id;
            bus.rd_ready = ($urandom_range(99) < pct);
            #1;
            chk({tag, "_rready"}, bus.RREADY, ar_done && k < n && bus.rd_ready);
            chk({tag, "_rd_valid"}, bus.rd_valid, ar_done && k < n && bus.RVALID);
            r_hs = bus.RVALID && bus.RREADY;
            if (r_hs) begin
                chk({tag, "_rd_data"}, bus.rd_data, exp_d);
                chk({tag, "_rd_last"}, bus.rd_last, k == eff_last);
                got_q.push_back(bus.rd_data);
                k++;
                if (k == n) r_final = 1;
            end
            if (bus.ARVALID && bus.ARREADY) ar_done = 1;
            @(negedge CLK);
        end
        chk({tag, "_beats"}, k, n);
        finish_cmd(tag, fin, er, ee);
    endtask

    initial begin
        bit          wr;
        logic [31:0] a;
        logic [3:0]  id;
        int          len;
        idle_inputs();
        set_defaults();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_valids", {bus.AWVALID, bus.ARVALID, bus.WVALID}, 3'b000);
        chk("rst_readys", {bus.BREADY, bus.RREADY}, 2'b00);
        chk("rst_done", {bus.done, bus.done_resp, bus.done_err}, 4'b0000);
        chk("rst_aw_fields", {bus.AWADDR, bus.AWID, bus.AWLEN}, '0);
        chk("rst_ar_fields", {bus.ARADDR, bus.ARID, bus.ARLEN}, '0);
        RST = 1'b0;

        // write with AW stall, then read it back with a throttled sink
        for (int j = 0; j < 4; j++) wdata[j] = 32'hA0 + 32'(j);
        aw_stall = 2; bid_val = 4'd3;
        do_write("wr_basic", 32'h100, 4'd3, 3);
        set_defaults(); got_q.delete();
        do_read("rd_basic", 32'h100, 4'd3, 3);
        chk("rd_basic_count", got_q.size(), 4);
        for (int j = 0; j < 4 && j < got_q.size(); j++) chk("rd_basic_value", got_q[j], 32'hA0 + 32'(j));

        // 4 KB crossing rejected; exact page end accepted
        set_defaults();
        do_write("wr_cross4k", 32'hFF8, 4'd2, 3);
        do_read("rd_cross4k", 32'h1FFC, 4'd2, 1);
        for (int j = 0; j < 4; j++) wdata[j] = $urandom;
        bid_val = 4'd6;
        do_write("wr_page_end", 32'hFF0, 4'd6, 3);

        // early RLAST with an error response on the first beat
        set_defaults(); rlast_at = 1; rresp_arr[0] = 2'b10; rresp_arr[1] = 2'b00;
        do_read("rd_early_last", 32'h100, 4'd3, 3);

        // BID mismatch
        set_defaults(); bid_val = 4'd5; bresp_val = 2'b01; wdata[0] = 32'h1234_5678;
        do_write("wr_bid_bad", 32'h300, 4'd3, 0);

        // reset mid-burst then a normal single-beat write
        set_defaults(); abort_beat = 2;
        for (int j = 0; j < 8; j++) wdata[j] = $urandom;
        do_write("wr_abort", 32'h400, 4'd7, 7);
        set_defaults(); bid_val = 4'd1; wdata[0] = 32'hCAFE_F00D;
        do_write("wr_after_rst", 32'h200, 4'd1, 0);

        // maximum length burst
        set_defaults(); pct = 90; bid_val = 4'd9;
        for (int j = 0; j < 256; j++) wdata[j] = $urandom;
        do_write("wr_len255", 32'h0, 4'd9, 255);
        set_defaults(); pct = 90;
        do_read("rd_len255", 32'h0, 4'd9, 255);

        // randomized commands
        for (int t = 0; t < 30; t++) begin
            set_defaults();
            pct = $urandom_range(30, 100);
            wr  = $urandom_range(1);
            a   = 32'($urandom_range(0, 2047)) * 4;
            id  = 4'($urandom);
            len = ($urandom_range(3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
            aw_stall = $urandom_range(0, 3); ar_stall = $urandom_range(0, 3);
            if (wr) begin
                for (int j = 0; j <= len; j++) wdata[j] = $urandom;
                bresp_val = 2'($urandom);
                bid_val   = ($urandom_range(3) == 0) ? 4'($urandom) : id;
                do_write("rand_wr", a, id, len);
            end else begin
                for (int j = 0; j <= len + 2; j++)
                    rresp_arr[j] = ($urandom_range(7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                if ($urandom_range(4) == 0) rlast_at = $urandom_range(0, len + 2);
                if ($urandom_range(5) == 0) rid_bad_at = $urandom_range(0, len);
                do_read("rand_rd", a, id, len);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
